mbox_wr_arb: RTL and testbench
==============================

MBOX_WR_ARB -- requirements
Module: mbox_wr_arb

Interface
REQ-001 Parameter WIDTH_ADDR, default 8: mailbox word-address width.
REQ-002 Parameter W_WIDTH_SYS, default 32: mailbox data-word width.
REQ-003 Parameter N_NUMB_CPU, default 4: number of CPU write ports.
REQ-004 Parameter FIFO_DATA, default 32+WIDTH_ADDR+W_WIDTH_SYS: stream word width.
REQ-005 Parameter FIFO_DEPTH, default 4: entries in the output buffer; power of two, at least 2.
REQ-006 One clock; reset is asynchronous and active-low.
REQ-007 clk  input  1  sole clock; all state changes on its rising edge.
REQ-008 rstn  input  1  asynchronous active-low reset.
REQ-009 wr_req_i  input  N_NUMB_CPU  per-CPU write request level.
REQ-010 wr_addr_i  input  N_NUMB_CPU*WIDTH_ADDR  per-CPU target address; CPU k uses slice [k*WIDTH_ADDR +: WIDTH_ADDR].
REQ-011 wr_data_i  input  N_NUMB_CPU*W_WIDTH_SYS  per-CPU write data; CPU k uses slice [k*W_WIDTH_SYS +: W_WIDTH_SYS].
REQ-012 wr_ack_o  output  N_NUMB_CPU  one-cycle completion pulse per CPU.
REQ-013 wr_err_o  output  N_NUMB_CPU  one-cycle error pulse, coincident with wr_ack_o.
REQ-014 m_tdata_o  output  FIFO_DATA  stream word {cpu number[31:0], addr, data}; data in the low W_WIDTH_SYS bits, addr above it, cpu number in the top 32 bits.
REQ-015 m_tvalid_o  output  1  stream word valid.
REQ-016 m_tready_i  input  1  downstream accepts the word.

Function
REQ-017 A request from CPU k is eligible when wr_req_i[k]=1, served[k]=0, and no ack for k is pending.
REQ-018 Arbitration is round-robin and runs every cycle: at most one grant per cycle, to the first eligible CPU, searching upward (with wrap) from last_grant+1.
REQ-019 A grant with addr < N_NUMB_CPU*N_NUMB_CPU is valid: the word {k, addr, data} is pushed into the FIFO in the grant cycle, and wr_ack_o[k] pulses exactly one cycle later.
REQ-020 A grant with addr >= N_NUMB_CPU*N_NUMB_CPU is invalid: nothing is pushed, and wr_ack_o[k] and wr_err_o[k] pulse together one cycle later.
REQ-021 A valid grant is issued only when the FIFO is not full, or when it is full and a pop occurs in the same cycle; an invalid grant is issued regardless of FIFO state.
REQ-022 On any grant to k: served[k] is set and last_grant becomes k; served[k] clears on the first cycle wr_req_i[k]=0.
REQ-023 A CPU holding req high after its ack is not granted again until it drops req for at least one cycle.
REQ-024 FIFO: first-word fall-through; m_tvalid_o=(count!=0); m_tdata_o is the head entry.
REQ-025 A pop occurs when m_tvalid_o and m_tready_i are both high.
REQ-026 Simultaneous push and pop leaves count unchanged.
REQ-027 Read and write pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
REQ-028 Words leave the FIFO in grant order; m_tdata_o is held stable while m_tvalid_o=1 and m_tready_i=0.
REQ-029 wr_data_i and wr_addr_i are sampled only in the grant cycle; later changes do not affect the queued word.

Reset
REQ-030 While rstn=0, all outputs read 0: wr_ack_o, wr_err_o, m_tvalid_o and m_tdata_o.
REQ-031 While rstn=0: FIFO pointers and count are 0, served is all 0, and last_grant = N_NUMB_CPU-1, so CPU 0 has first priority after reset.
REQ-032 Reset asserted mid-operation discards all queued words and any pending acks; no ack is issued for a discarded word.
REQ-033 Release of rstn is synchronised to clk by the integrating design; the first grant occurs no earlier than the first rising edge with rstn=1.

Verification
REQ-034 Single write, default parameters: CPU2 writes addr 9, data 0xA5A5A5A5, m_tready_i=1 -> next cycle m_tvalid_o=1 with m_tdata_o={32'd2, 8'd9, 32'hA5A5A5A5}, and wr_ack_o=4'b0100 for one cycle.
REQ-035 All four CPUs request in the same cycle after reset -> grants in order 0,1,2,3 on consecutive cycles, and the stream carries cpu numbers 0,1,2,3.
REQ-036 Invalid address: CPU1 writes addr 16 -> wr_ack_o[1] and wr_err_o[1] pulse one cycle later, and m_tvalid_o stays 0.
REQ-037 Full buffer: m_tready_i=0 with 5 requests -> 4 words queued and the 5th is held without ack; raise m_tready_i for one cycle -> one pop, then the 5th word is granted and acked.
REQ-038 Request held high: CPU0 keeps wr_req_i[0]=1 for 10 cycles -> exactly one ack; drop req for one cycle and raise again -> a second grant.
REQ-039 Reset mid-operation: assert rstn=0 with 3 words queued -> m_tvalid_o=0 immediately, and after release no stale word or ack appears.

Source files
------------

// File: rtl/mbox_wr_arb.sv
// Mailbox write arbiter: round-robin grant among CPU write ports, valid
// writes are queued as {cpu, addr, data} words in a fall-through FIFO that
// drives a ready/valid stream; every grant is acked one cycle later, and
// out-of-range addresses are acked with an error instead of being queued.

// Per-CPU state: served flag, ack/err pulse registers, address range check.
module mbox_wr_arb_lane #(
  parameter int WIDTH_ADDR = 8,
  parameter int LIMIT      = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req,
  input  logic                  grant,
  input  logic [WIDTH_ADDR-1:0] addr,
  output logic                  elig,
  output logic                  addr_ok,
  output logic                  ack,
  output logic                  err
);
  logic served;

  assign addr_ok = (32'(addr) < 32'(LIMIT));
  // A CPU holding req after its grant must drop it before it can win again.
  assign elig    = req & ~served & ~ack;

  // served latches on grant and clears on the first cycle req is low
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       served <= 1'b0;
    else if (grant)  served <= 1'b1;
    else if (!req)   served <= 1'b0;
  end

  // completion/error pulses one cycle after the grant
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ack <= 1'b0;
      err <= 1'b0;
    end else begin
      ack <= grant;
      err <= grant & ~addr_ok;
    end
  end
endmodule

module mbox_wr_arb #(
  parameter int WIDTH_ADDR  = 8,
  parameter int W_WIDTH_SYS = 32,
  parameter int N_NUMB_CPU  = 4,
  parameter int FIFO_DATA   = 32 + WIDTH_ADDR + W_WIDTH_SYS,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [N_NUMB_CPU-1:0]             wr_req_i,
  input  logic [N_NUMB_CPU*WIDTH_ADDR-1:0]  wr_addr_i,
  input  logic [N_NUMB_CPU*W_WIDTH_SYS-1:0] wr_data_i,
  output logic [N_NUMB_CPU-1:0]             wr_ack_o,
  output logic [N_NUMB_CPU-1:0]             wr_err_o,
  output logic [FIFO_DATA-1:0]              m_tdata_o,
  output logic                              m_tvalid_o,
  input  logic                              m_tready_i
);
  localparam int CW    = (N_NUMB_CPU > 1) ? $clog2(N_NUMB_CPU) : 1;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int LIMIT = N_NUMB_CPU * N_NUMB_CPU;

  logic [N_NUMB_CPU-1:0] elig, addr_ok, cand, lane_gnt;
  logic [CW-1:0]         last_grant, gnt_idx;
  logic                  gnt_any, push, pop, can_push;

  logic [FIFO_DATA-1:0]  mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [PW:0]           count;

  mbox_wr_arb_lane #(.WIDTH_ADDR(WIDTH_ADDR), .LIMIT(LIMIT)) u_lane [N_NUMB_CPU-1:0] (
    .clk    (clk),
    .rstn   (rstn),
    .req    (wr_req_i),
    .grant  (lane_gnt),
    .addr   (wr_addr_i),
    .elig   (elig),
    .addr_ok(addr_ok),
    .ack    (wr_ack_o),
    .err    (wr_err_o)
  );

  assign m_tvalid_o = (count != '0);
  assign m_tdata_o  = m_tvalid_o ? mem[rd_ptr] : '0;
  assign pop        = m_tvalid_o & m_tready_i;
  assign can_push   = (count != (PW+1)'(FIFO_DEPTH)) | pop;
  // Error writes never touch the FIFO, so they may win even when it is full.
  assign cand       = elig & (~addr_ok | {N_NUMB_CPU{can_push}});

  // round-robin search upward from last_grant+1 with wrap
  always_comb begin : rr_search
    logic [CW:0] idx;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int i = 1; i <= N_NUMB_CPU; i++) begin
      idx = {1'b0, last_grant} + (CW+1)'(i);
      if (idx >= (CW+1)'(N_NUMB_CPU)) idx = idx - (CW+1)'(N_NUMB_CPU);
      if (!gnt_any && cand[idx[CW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = idx[CW-1:0];
      end
    end
  end

  assign lane_gnt = gnt_any ? (N_NUMB_CPU'(1) << gnt_idx) : '0;
  assign push     = gnt_any & addr_ok[gnt_idx];

  // remember the last winner; reset value gives CPU 0 first priority
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        last_grant <= CW'(N_NUMB_CPU - 1);
    else if (gnt_any) last_grant <= gnt_idx;
  end

  // FIFO storage: word is captured from the CPU inputs in the grant cycle
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= FIFO_DATA'({32'(gnt_idx),
                                 wr_addr_i[gnt_idx*WIDTH_ADDR +: WIDTH_ADDR],
                                 wr_data_i[gnt_idx*W_WIDTH_SYS +: W_WIDTH_SYS]});
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + (PW+1)'(1);
      else if (pop && !push) count <= count - (PW+1)'(1);
    end
  end
endmodule

// File: tb/tb_mbox_wr_arb.sv
// Randomized and directed bench for mbox_wr_arb: a reference model predicts
// grants, acks and stream words; a monitor checks the DUT each cycle.
module tb_mbox_wr_arb;
  localparam int N  = 4;
  localparam int WA = 8;
  localparam int WS = 32;
  localparam int FD = 32 + WA + WS;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N-1:0]    wr_req_i;
  logic [N*WA-1:0] wr_addr_i;
  logic [N*WS-1:0] wr_data_i;
  logic [N-1:0]    wr_ack_o, wr_err_o;
  logic [FD-1:0]   m_tdata_o;
  logic            m_tvalid_o, m_tready_i;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [FD-1:0] exp_q[$];
  int            mcount;
  logic [N-1:0]  served, eack, eerr;
  int            last;

  mbox_wr_arb dut (
    .clk(clk), .rstn(rstn), .wr_req_i(wr_req_i), .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i), .wr_ack_o(wr_ack_o), .wr_err_o(wr_err_o),
    .m_tdata_o(m_tdata_o), .m_tvalid_o(m_tvalid_o), .m_tready_i(m_tready_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: applies the arbitration rules once per rising edge.
  initial begin
    exp_q.delete(); mcount = 0; served = '0; eack = '0; eerr = '0; last = N - 1;
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        exp_q.delete(); mcount = 0; served = '0; eack = '0; eerr = '0; last = N - 1;
      end else begin
        bit pop, can;
        int g;
        logic [N-1:0] nack, nerr;
        pop = (mcount > 0) && m_tready_i;
        can = (mcount < DEPTH) || pop;
        g = -1;
        for (int i = 1; i <= N; i++) begin
          int k;
          k = (last + i) % N;
          if (g < 0 && wr_req_i[k] && !served[k] && !eack[k] &&
              (int'(wr_addr_i[k*WA +: WA]) >= N*N || can))
            g = k;
        end
        for (int k = 0; k < N; k++) if (!wr_req_i[k]) served[k] = 1'b0;
        nack = '0; nerr = '0;
        if (g >= 0) begin
          served[g] = 1'b1;
          last = g;
          nack[g] = 1'b1;
          if (int'(wr_addr_i[g*WA +: WA]) >= N*N) nerr[g] = 1'b1;
          else begin
            exp_q.push_back({32'(g), wr_addr_i[g*WA +: WA], wr_data_i[g*WS +: WS]});
            mcount++;
          end
        end
        if (pop) mcount--;
        eack = nack;
        eerr = nerr;
      end
    end
  end

  // Monitor: compares outputs against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rstn) begin
        chk("rst_ack", 128'(wr_ack_o), 128'(0));
        chk("rst_err", 128'(wr_err_o), 128'(0));
        chk("rst_tvalid", 128'(m_tvalid_o), 128'(0));
        chk("rst_tdata", 128'(m_tdata_o), 128'(0));
      end else begin
        chk("ack", 128'(wr_ack_o), 128'(eack));
        chk("err", 128'(wr_err_o), 128'(eerr));
        chk("tvalid", 128'(m_tvalid_o), 128'(mcount != 0));
        if (m_tvalid_o && m_tready_i) begin
          if (exp_q.size() == 0) chk("pop_unexpected", 128'(1), 128'(0));
          else chk("tdata", 128'(m_tdata_o), 128'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_cpu(input int k, input logic [WA-1:0] a, input logic [WS-1:0] d);
    wr_addr_i[k*WA +: WA] = a;
    wr_data_i[k*WS +: WS] = d;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step(2);
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; wr_req_i = '0; wr_addr_i = '0; wr_data_i = '0; m_tready_i = 1'b0;
    step(3);
    rstn = 1'b1;

    // single valid write from CPU2
    m_tready_i = 1'b1;
    set_cpu(2, 8'd9, 32'hA5A5A5A5);
    wr_req_i = 4'b0100;
    step(1);
    chk("single_tvalid", 128'(m_tvalid_o), 128'(1));
    chk("single_tdata", 128'(m_tdata_o), 128'({32'd2, 8'd9, 32'hA5A5A5A5}));
    chk("single_ack", 128'(wr_ack_o), 128'(4'b0100));
    wr_req_i = '0;
    step(1);
    chk("single_ack_off", 128'(wr_ack_o), 128'(0));
    step(2);

    // all four CPUs at once right after reset: grants 0,1,2,3
    do_reset();
    for (int k = 0; k < N; k++) set_cpu(k, WA'(k + 1), 32'h1000 + k);
    wr_req_i = 4'b1111;
    for (int k = 0; k < N; k++) begin
      step(1);
      chk("rr_ack", 128'(wr_ack_o), 128'(4'b0001 << k));
    end
    wr_req_i = '0;
    step(3);

    // out-of-range address
    set_cpu(1, 8'd16, 32'hDEAD);
    wr_req_i = 4'b0010;
    step(1);
    chk("inv_ack", 128'(wr_ack_o), 128'(4'b0010));
    chk("inv_err", 128'(wr_err_o), 128'(4'b0010));
    chk("inv_tvalid", 128'(m_tvalid_o), 128'(0));
    wr_req_i = '0;
    step(2);

    // full buffer: 4 queued, 5th held until a pop frees a slot
    m_tready_i = 1'b0;
    for (int k = 0; k < N; k++) set_cpu(k, WA'(k), 32'h2000 + k);
    wr_req_i = 4'b1111;
    step(4);
    wr_req_i = '0;
    step(1);
    set_cpu(0, 8'd15, 32'h55AA);
    wr_req_i = 4'b0001;
    step(3);
    chk("full_hold_ack", 128'(wr_ack_o), 128'(0));
    m_tready_i = 1'b1;
    step(1);
    m_tready_i = 1'b0;
    chk("full_5th_ack", 128'(wr_ack_o), 128'(4'b0001));
    step(2);
    wr_req_i = '0;
    m_tready_i = 1'b1;
    step(6);

    // request held high: one grant until req drops
    set_cpu(0, 8'd3, 32'h77);
    wr_req_i = 4'b0001;
    step(10);
    wr_req_i = '0;
    step(1);
    wr_req_i = 4'b0001;
    step(1);
    chk("rehold_ack", 128'(wr_ack_o), 128'(4'b0001));
    wr_req_i = '0;
    step(3);

    // reset with words queued
    m_tready_i = 1'b0;
    wr_req_i = 4'b0111;
    step(3);
    wr_req_i = '0;
    rstn = 1'b0;
    #1;
    chk("midrst_tvalid", 128'(m_tvalid_o), 128'(0));
    chk("midrst_ack", 128'(wr_ack_o), 128'(0));
    step(2);
    rstn = 1'b1;
    m_tready_i = 1'b1;
    step(5);

    // randomized traffic, including data changes while requests are held
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 3) == 0) wr_req_i[k] = ~wr_req_i[k];
        if ($urandom_range(0, 2) == 0)
          set_cpu(k, ($urandom_range(0, 4) == 0) ? WA'($urandom_range(0, 255))
                                                 : WA'($urandom_range(0, 15)),
                  WS'($urandom));
      end
      m_tready_i = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 599) == 0) begin
        rstn = 1'b0;
        step(2);
        rstn = 1'b1;
      end else begin
        step(1);
      end
    end

    wr_req_i = '0;
    m_tready_i = 1'b1;
    step(10);
    chk("drain_empty", 128'(exp_q.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
